pour_timer: RTL and testbench

Pour-sequence timer that drives the single-digit seven-segment display decoder and the pump. When a start request arrives it runs the pump for a fixed number of seconds and shows the remaining seconds as a BCD digit. When the count finishes it holds "0" briefly, then blanks the display. Its `value` output connects directly to the 4-bit input of the display decoder, and code 4'hA means blank.

---
 rtl/pour_timer.sv | 137 +++++++++++++
 tb/tb_pour_timer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pour_timer.sv
// Pour-sequence timer: runs the pump for POUR_SEC seconds, shows the remaining seconds, then holds "0".
// Optional cup sensing (pause/resume, start gating) is enabled with `define POUR_CUP_CHECK_EN.
module pour_timer #(
  parameter int TICK_DIV = 100_000_000,
  parameter int POUR_SEC = 5,
  parameter int DONE_SEC = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       cancel,
  input  logic       cup_present,
  output logic [3:0] value,
  output logic       pump_on,
  output logic       busy,
  output logic       done
);

  localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
  localparam logic [3:0] POUR_REM = 4'(POUR_SEC);
  localparam logic [3:0] DONE_REM = 4'(DONE_SEC);
  localparam logic [3:0] BLANK = 4'hA;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POUR  = 2'd1,
`ifdef POUR_CUP_CHECK_EN
    PAUSE = 2'd3,
`endif
    HOLD  = 2'd2
  } state_t;

  state_t           state;
  logic [PRE_W-1:0] pre;
  logic [3:0]       rem;
  logic             tick;
  logic             start_ok;

  assign tick = (pre == PRE_MAX);

`ifdef POUR_CUP_CHECK_EN
  assign start_ok = start && !cancel && cup_present;
`else
  assign start_ok = start && !cancel;
  logic unused_cup;
  assign unused_cup = cup_present;
`endif

  // Outputs are written alongside the state so they always match the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      pre     <= '0;
      rem     <= '0;
      value   <= BLANK;
      pump_on <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && cancel) begin
        state   <= IDLE;
        pre     <= '0;
        rem     <= '0;
        value   <= BLANK;
        pump_on <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            pre <= '0;
            if (start_ok) begin
              state   <= POUR;
              rem     <= POUR_REM;
              value   <= POUR_REM;
              pump_on <= 1'b1;
              busy    <= 1'b1;
            end
          end
          POUR: begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick && rem == 4'd1) begin
              state   <= HOLD;
              rem     <= DONE_REM;
              value   <= 4'd0;
              pump_on <= 1'b0;
              done    <= 1'b1;
            end else begin
              if (tick) begin
                rem   <= rem - 4'd1;
                value <= rem - 4'd1;
              end
`ifdef POUR_CUP_CHECK_EN
              // The cycle that saw the cup leave still counted as pump time.
              if (!cup_present) begin
                state   <= PAUSE;
                pump_on <= 1'b0;
              end
`endif
            end
          end
`ifdef POUR_CUP_CHECK_EN
          PAUSE: begin
            if (cup_present) begin
              state   <= POUR;
              pump_on <= 1'b1;
            end
          end
`endif
          HOLD: begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) begin
              if (rem <= 4'd1) begin
                state <= IDLE;
                rem   <= '0;
                value <= BLANK;
                busy  <= 1'b0;
              end else begin
                rem <= rem - 4'd1;
              end
            end
          end
          default: begin
            state   <= IDLE;
            pre     <= '0;
            rem     <= '0;
            value   <= BLANK;
            pump_on <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pour_timer.sv
// Testbench for pour_timer: compares the DUT with a cycle-count model of the pour sequence.
// Cup-sensing scenarios are selected by `define POUR_CUP_CHECK_EN.
module tb_pour_timer;

  localparam int TICK_DIV = 4;
  localparam int POUR_SEC = 3;
  localparam int DONE_SEC = 2;
  localparam int POUR_CYC = POUR_SEC * TICK_DIV;
  localparam int HOLD_CYC = DONE_SEC * TICK_DIV;
`ifdef POUR_CUP_CHECK_EN
  localparam bit CUP_EN = 1'b1;
`else
  localparam bit CUP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       cancel = 1'b0;
  logic       cup_present = 1'b1;
  logic [3:0] value;
  logic       pump_on;
  logic       busy;
  logic       done;

  int total = 0;
  int bad = 0;

  pour_timer #(.TICK_DIV(TICK_DIV), .POUR_SEC(POUR_SEC), .DONE_SEC(DONE_SEC)) dut (
    .clk(clk), .reset(reset), .start(start), .cancel(cancel), .cup_present(cup_present),
    .value(value), .pump_on(pump_on), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Model: mode 0 idle, 1 pouring, 2 holding, 3 paused; m_el counts pump-on cycles so far.
  int   m_mode = 0;
  int   m_el = 0;
  int   m_hold = 0;
  logic m_done = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode <= 0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      case (m_mode)
        0: if (start && !cancel && (!CUP_EN || cup_present)) begin
             m_mode <= 1;
             m_el   <= 0;
           end
        1: if (cancel) m_mode <= 0;
           else begin
             m_el <= m_el + 1;
             if (m_el + 1 == POUR_CYC) begin
               m_mode <= 2;
               m_hold <= 0;
               m_done <= 1'b1;
             end else if (CUP_EN && !cup_present) m_mode <= 3;
           end
        2: if (cancel || m_hold + 1 == HOLD_CYC) m_mode <= 0;
           else m_hold <= m_hold + 1;
        default: if (cancel) m_mode <= 0;
                 else if (cup_present) m_mode <= 1;
      endcase
    end
  end

  function automatic logic [3:0] exp_value();
    case (m_mode)
      1, 3:    return 4'(POUR_SEC - m_el / TICK_DIV);
      2:       return 4'd0;
      default: return 4'hA;
    endcase
  endfunction

  task automatic drive(input logic s, input logic c, input logic cup);
    start = s;
    cancel = c;
    cup_present = cup;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int done_cnt = 0;
    #1 reset = 1'b0;
    #2;
    total++; if (value !== 4'hA) begin bad++; $display("[TB] FAIL reset.value got %h want a", value); end
    total++; if (pump_on !== 1'b0) begin bad++; $display("[TB] FAIL reset.pump got %b want 0", pump_on); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset.busy got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset.done got %b want 0", done); end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 1'b1);
      if (done) done_cnt++;
      total++; if (value !== 4'hA || busy !== 1'b0 || pump_on !== 1'b0) begin
        bad++; $display("[TB] FAIL idle cycle %0d got value=%h busy=%b pump=%b want a/0/0", i, value, busy, pump_on);
      end
    end
    total++; if (done_cnt !== 0) begin bad++; $display("[TB] FAIL idle.done pulses got %0d want 0", done_cnt); end
  endtask

  task automatic test_pour();
    int pump_cnt = 0;
    int done_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      drive(i == 0, 1'b0, 1'b1);
      if (pump_on) pump_cnt++;
      if (done) done_cnt++;
      total++; if (value !== exp_value()) begin bad++; $display("[TB] FAIL pour.value cycle %0d got %h want %h", i, value, exp_value()); end
      total++; if (pump_on !== (m_mode == 1)) begin bad++; $display("[TB] FAIL pour.pump cycle %0d got %b want %b", i, pump_on, m_mode == 1); end
      total++; if (busy !== (m_mode != 0)) begin bad++; $display("[TB] FAIL pour.busy cycle %0d got %b want %b", i, busy, m_mode != 0); end
      total++; if (done !== m_done) begin bad++; $display("[TB] FAIL pour.done cycle %0d got %b want %b", i, done, m_done); end
    end
    total++; if (pump_cnt !== POUR_CYC) begin bad++; $display("[TB] FAIL pour.ontime got %0d want %0d", pump_cnt, POUR_CYC); end
    total++; if (done_cnt !== 1) begin bad++; $display("[TB] FAIL pour.donecount got %0d want 1", done_cnt); end
  endtask

  task automatic test_cancel();
    int done_cnt = 0;
    for (int i = 0; i < 5; i++) drive(i == 0, 1'b0, 1'b1);
    total++; if (value !== 4'd2) begin bad++; $display("[TB] FAIL cancel.pre value got %h want 2", value); end
    drive(1'b0, 1'b1, 1'b1);
    total++; if (value !== 4'hA || pump_on !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL cancel.idle got value=%h pump=%b busy=%b want a/0/0", value, pump_on, busy);
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, 1'b1);
      if (done) done_cnt++;
      total++; if (busy !== (m_mode != 0) || value !== exp_value()) begin
        bad++; $display("[TB] FAIL cancel.after cycle %0d got busy=%b value=%h want %b/%h", i, busy, value, m_mode != 0, exp_value());
      end
    end
    total++; if (done_cnt !== 0) begin bad++; $display("[TB] FAIL cancel.done pulses got %0d want 0", done_cnt); end
  endtask

  task automatic test_back_to_back();
    int done_cnt = 0;
    int starts = 0;
    logic prev_busy = 1'b0;
    for (int i = 0; i < 24; i++) begin
      drive(i < POUR_CYC, 1'b0, 1'b1);
      if (done) done_cnt++;
      if (busy && !prev_busy) starts++;
      prev_busy = busy;
      total++; if (value !== exp_value() || pump_on !== (m_mode == 1)) begin
        bad++; $display("[TB] FAIL held.cycle %0d got value=%h pump=%b want %h/%b", i, value, pump_on, exp_value(), m_mode == 1);
      end
    end
    total++; if (starts !== 1 || done_cnt !== 1) begin bad++; $display("[TB] FAIL held.count got starts=%0d dones=%0d want 1/1", starts, done_cnt); end
    drive(1'b1, 1'b1, 1'b1);
    total++; if (busy !== 1'b0 || value !== 4'hA) begin bad++; $display("[TB] FAIL startcancel got busy=%b value=%h want 0/a", busy, value); end
    drive(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) drive(i == 0, 1'b0, 1'b1);
    total++; if (pump_on !== 1'b1) begin bad++; $display("[TB] FAIL areset.pre pump got %b want 1", pump_on); end
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    total++; if (pump_on !== 1'b0 || value !== 4'hA || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL areset.immediate got pump=%b value=%h busy=%b want 0/a/0", pump_on, value, busy);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 1'b1);
      total++; if (busy !== 1'b0 || value !== 4'hA) begin bad++; $display("[TB] FAIL areset.after cycle %0d got busy=%b value=%h want 0/a", i, busy, value); end
    end
  endtask

  task automatic test_cup();
    int pump_cnt = 0;
    int done_cnt = 0;
    logic cup;
    drive(1'b1, 1'b0, CUP_EN ? 1'b0 : 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    if (CUP_EN) begin
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL cup.nocup start got busy=%b want 0", busy); end
    end else begin
      drive(1'b0, 1'b1, 1'b1);
    end
    for (int i = 0; i < 35; i++) begin
      cup = !(i >= 5 && i < 11);
      drive(i == 0, 1'b0, cup);
      if (pump_on) pump_cnt++;
      if (done) done_cnt++;
      if (CUP_EN && i >= 5 && i < 11) begin
        total++; if (pump_on !== 1'b0 || value !== 4'd2) begin bad++; $display("[TB] FAIL cup.pause cycle %0d got pump=%b value=%h want 0/2", i, pump_on, value); end
      end
      total++; if (value !== exp_value() || pump_on !== (m_mode == 1) || done !== m_done) begin
        bad++; $display("[TB] FAIL cup.cycle %0d got value=%h pump=%b done=%b want %h/%b/%b", i, value, pump_on, done, exp_value(), m_mode == 1, m_done);
      end
    end
    total++; if (pump_cnt !== POUR_CYC || done_cnt !== 1) begin bad++; $display("[TB] FAIL cup.ontime got %0d dones=%0d want %0d/1", pump_cnt, done_cnt, POUR_CYC); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 5) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 4) != 0);
      total++; if (value !== exp_value() || pump_on !== (m_mode == 1) || busy !== (m_mode != 0) || done !== m_done) begin
        bad++; $display("[TB] FAIL random cycle %0d got value=%h pump=%b busy=%b done=%b want %h/%b/%b/%b",
                        i, value, pump_on, busy, done, exp_value(), m_mode == 1, m_mode != 0, m_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pour();
    test_cancel();
    test_back_to_back();
    test_async_reset();
    test_cup();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
